// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, control bundle and bubble constant for the MEM stage
package mem_stage_pkg;

    localparam int DMEM_DEPTH_DEF = 256;
    localparam int REG_W          = 5;
    localparam int DATA_W         = 32;

    // Control bits carried through EX/MEM; ordering matches the ex_* port list.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic memto_reg;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_BUBBLE = '0;

    // An invalid slot must never carry live control bits into MEM.
    function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t c, input logic valid);
        return valid ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word memory with one synchronous write port and one asynchronous read port
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset by design; only explicit writes change them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: EX/MEM register, branch resolve, data memory, MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int ADDR_W     = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_branch_addr,
    input  logic [REG_W-1:0]  ex_reg_dst,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_Branch,
    input  logic              ex_RegWrite,
    input  logic              ex_MemtoReg,
    input  logic              hold,
    input  logic              flush,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err
);

    mem_ctrl_t         ex_ctrl;
    mem_ctrl_t         mem_ctrl;
    logic              mem_valid;
    logic              mem_zero;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_branch_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [REG_W-1:0]  mem_reg_dst;

    logic              access;
    logic              misaligned;
    logic              mem_we;
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_sel;

    assign ex_ctrl = {ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite, ex_MemtoReg};

    assign pc_src        = mem_valid & mem_ctrl.branch & mem_zero;
    assign branch_target = mem_branch_addr;

    // Upper address bits are dropped, so accesses wrap modulo the memory depth.
    assign word_idx   = mem_alu_result[ADDR_W+1:2];
    assign access     = mem_valid & (mem_ctrl.mem_read | mem_ctrl.mem_write);
    assign misaligned = access & (|mem_alu_result[1:0]);

    // Reset in the same cycle as a store cancels it.
    assign mem_we    = mem_valid & mem_ctrl.mem_write & ~misaligned & ~hold & ~reset;
    assign load_data = misaligned ? '0 : rd_word;
    assign wb_sel    = mem_ctrl.memto_reg ? load_data : mem_alu_result;

    data_memory #(
        .DEPTH (DMEM_DEPTH),
        .AW    (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .widx  (word_idx),
        .wdata (mem_write_data),
        .ridx  (word_idx),
        .rdata (rd_word)
    );

    // EX/MEM register: bubble on flush or on a taken branch (squashes the wrong-path op).
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid       <= 1'b0;
            mem_ctrl        <= CTRL_BUBBLE;
            mem_zero        <= 1'b0;
            mem_alu_result  <= '0;
            mem_branch_addr <= '0;
            mem_write_data  <= '0;
            mem_reg_dst     <= '0;
        end else if (!hold) begin
            mem_zero        <= ex_zero;
            mem_alu_result  <= ex_alu_result;
            mem_branch_addr <= ex_branch_addr;
            mem_write_data  <= ex_write_data;
            mem_reg_dst     <= ex_reg_dst;
            if (flush || pc_src) begin
                mem_valid <= 1'b0;
                mem_ctrl  <= CTRL_BUBBLE;
            end else begin
                mem_valid <= ex_valid;
                mem_ctrl  <= gate_ctrl(ex_ctrl, ex_valid);
            end
        end
    end

    // MEM/WB register: write-back payload, frozen while held.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
        end else if (!hold) begin
            wb_valid    <= mem_valid;
            wb_RegWrite <= mem_ctrl.reg_write;
            wb_reg      <= mem_reg_dst;
            wb_data     <= wb_sel;
        end
    end

    // Sticky misalignment flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed self-checking bench for mem_stage
module tb_mem_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] baddr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        mr;
        logic        mw;
        logic        br;
        logic        rw;
        logic        m2r;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic        ex_zero;
    logic [31:0] ex_branch_addr;
    logic [4:0]  ex_reg_dst;
    logic [31:0] ex_write_data;
    logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite, ex_MemtoReg;
    logic        hold, flush;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    // reference state: instruction in MEM, expected write-back, memory image
    instr_t      m_mem;
    bit          m_known;
    bit          bt_known;
    logic [31:0] bt_val;
    logic        e_wbv, e_wbrw, e_err;
    logic [4:0]  e_wbreg;
    logic [31:0] e_wbdata;
    bit          wb_known;
    logic [31:0] dmem [256];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_zero        (ex_zero),
        .ex_branch_addr (ex_branch_addr),
        .ex_reg_dst     (ex_reg_dst),
        .ex_write_data  (ex_write_data),
        .ex_MemRead     (ex_MemRead),
        .ex_MemWrite    (ex_MemWrite),
        .ex_Branch      (ex_Branch),
        .ex_RegWrite    (ex_RegWrite),
        .ex_MemtoReg    (ex_MemtoReg),
        .hold           (hold),
        .flush          (flush),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .wb_valid       (wb_valid),
        .wb_RegWrite    (wb_RegWrite),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .misalign_err   (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t t = '0;
        return t;
    endfunction

    function automatic instr_t mk_sw(input logic [31:0] addr, input logic [31:0] data);
        instr_t t = '0;
        t.valid = 1'b1; t.alu = addr; t.wdata = data; t.mw = 1'b1;
        return t;
    endfunction

    function automatic instr_t mk_lw(input logic [31:0] addr, input logic [4:0] rd);
        instr_t t = '0;
        t.valid = 1'b1; t.alu = addr; t.rd = rd; t.mr = 1'b1; t.rw = 1'b1; t.m2r = 1'b1;
        return t;
    endfunction

    function automatic instr_t mk_alu(input logic [31:0] val, input logic [4:0] rd);
        instr_t t = '0;
        t.valid = 1'b1; t.alu = val; t.rd = rd; t.rw = 1'b1;
        return t;
    endfunction

    function automatic instr_t mk_br(input logic z, input logic [31:0] target);
        instr_t t = '0;
        t.valid = 1'b1; t.zero = z; t.baddr = target; t.br = 1'b1; t.alu = 32'd0;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        logic [31:0] a;
        int k;
        t = '0;
        k = $urandom_range(0, 9);
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
        t.valid = ($urandom_range(0, 9) != 0);
        t.alu   = a;
        t.zero  = 1'($urandom_range(0, 1));
        t.baddr = $urandom;
        t.rd    = 5'($urandom_range(0, 31));
        t.wdata = $urandom;
        case (k)
            0, 1, 2: t.rw = 1'b1;
            3, 4:    begin t.mr = 1'b1; t.rw = 1'b1; t.m2r = 1'b1; end
            5, 6:    t.mw = 1'b1;
            7:       t.br = 1'b1;
            8:       begin t.mr = 1'b1; t.mw = 1'b1; t.rw = 1'b1; t.m2r = 1'b1; end
            default: begin
                t.mr = 1'($urandom_range(0, 1)); t.mw = 1'($urandom_range(0, 1));
                t.br = 1'($urandom_range(0, 1)); t.rw = 1'($urandom_range(0, 1));
                t.m2r = 1'($urandom_range(0, 1));
            end
        endcase
        return t;
    endfunction

    // Reference behaviour of one clock edge, written from the stage's rules.
    task automatic model_edge(input instr_t in, input bit h, input bit f, input bit r);
        bit mis, taken;
        int idx;
        logic [31:0] old;
        if (r) begin
            m_mem = '0; m_known = 0;
            bt_known = 1; bt_val = 32'd0;
            e_wbv = 0; e_wbrw = 0; e_wbreg = 0; e_wbdata = 0; wb_known = 1;
            e_err = 0;
            return;
        end
        mis = m_mem.valid && (m_mem.mr || m_mem.mw) && (m_mem.alu % 4 != 0);
        if (mis) e_err = 1;
        if (h) return;
        idx = int'((m_mem.alu / 4) % 256);
        old = dmem[idx];
        if (m_mem.valid && m_mem.mw && !mis) dmem[idx] = m_mem.wdata;
        e_wbv    = m_mem.valid;
        e_wbrw   = m_mem.valid && m_mem.rw;
        e_wbreg  = m_mem.rd;
        e_wbdata = m_mem.m2r ? (mis ? 32'd0 : old) : m_mem.alu;
        wb_known = m_known;
        taken = m_mem.valid && m_mem.br && m_mem.zero;
        if (f || taken) begin
            m_mem = '0; m_known = 0; bt_known = 0;
        end else begin
            m_mem = in;
            if (!in.valid) begin
                m_mem.mr = 0; m_mem.mw = 0; m_mem.br = 0; m_mem.rw = 0; m_mem.m2r = 0;
            end
            m_known = 1; bt_known = 1; bt_val = in.baddr;
        end
    endtask

    task automatic step(input instr_t in, input bit h, input bit f, input bit r);
        @(negedge clk);
        reset          = r;
        hold           = h;
        flush          = f;
        ex_valid       = in.valid;
        ex_alu_result  = in.alu;
        ex_zero        = in.zero;
        ex_branch_addr = in.baddr;
        ex_reg_dst     = in.rd;
        ex_write_data  = in.wdata;
        ex_MemRead     = in.mr;
        ex_MemWrite    = in.mw;
        ex_Branch      = in.br;
        ex_RegWrite    = in.rw;
        ex_MemtoReg    = in.m2r;
        @(posedge clk);
        model_edge(in, h, f, r);
        #1;
        check("pc_src", 32'(pc_src), 32'(m_mem.valid && m_mem.br && m_mem.zero));
        if (bt_known) check("branch_target", branch_target, bt_val);
        check("wb_valid", 32'(wb_valid), 32'(e_wbv));
        check("wb_RegWrite", 32'(wb_RegWrite), 32'(e_wbrw));
        if (wb_known) begin
            check("wb_reg", 32'(wb_reg), 32'(e_wbreg));
            check("wb_data", wb_data, e_wbdata);
        end
        check("misalign_err", 32'(misalign_err), 32'(e_err));
    endtask

    initial begin
        instr_t t;
        m_mem = '0; m_known = 0; bt_known = 0; bt_val = 0;
        e_wbv = 0; e_wbrw = 0; e_wbreg = 0; e_wbdata = 0; e_err = 0; wb_known = 0;

        // reset, then fill memory through the stage so every word is known
        step(nop(), 0, 0, 1);
        step(nop(), 0, 0, 1);
        check("reset_wb_valid", 32'(wb_valid), 32'd0);
        check("reset_branch_target", branch_target, 32'd0);
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'hxxxx_xxxx;
            step(mk_sw(32'(i * 4), $urandom), 0, 0, 0);
        end
        step(nop(), 0, 0, 0);

        // store then load
        step(mk_sw(32'h40, 32'hDEAD_BEEF), 0, 0, 0);
        step(mk_lw(32'h40, 5'd5), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("sl_wb_data", wb_data, 32'hDEAD_BEEF);
        check("sl_wb_reg", 32'(wb_reg), 32'd5);
        check("sl_wb_valid", 32'(wb_valid), 32'd1);

        // taken branch squashes the following addi
        step(mk_br(1'b1, 32'h100), 0, 0, 0);
        check("br_pc_src", 32'(pc_src), 32'd1);
        check("br_target", branch_target, 32'h100);
        step(mk_alu(32'h11, 5'd7), 0, 0, 0);
        check("br_pc_src_one_cycle", 32'(pc_src), 32'd0);
        step(nop(), 0, 0, 0);
        check("br_addi_dropped", 32'(wb_valid), 32'd0);

        // not-taken branch lets the addi retire
        step(mk_br(1'b0, 32'h100), 0, 0, 0);
        check("nt_pc_src", 32'(pc_src), 32'd0);
        step(mk_alu(32'h11, 5'd7), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("nt_addi_valid", 32'(wb_valid), 32'd1);
        check("nt_addi_reg", 32'(wb_reg), 32'd7);

        // hold with a store in MEM
        step(mk_alu(32'h77, 5'd4), 0, 0, 0);
        t = mk_sw(32'h60, 32'h55AA);
        t.baddr = 32'hABC0;
        step(t, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(rnd_instr(), 1, 1, 0);
            check("hold_wb_reg", 32'(wb_reg), 32'd4);
            check("hold_wb_data", wb_data, 32'h77);
            check("hold_ex_mem", branch_target, 32'hABC0);
        end
        step(mk_lw(32'h60, 5'd6), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("hold_store_data", wb_data, 32'h55AA);

        // wrap-around
        step(mk_sw(32'h400, 32'h1234_5678), 0, 0, 0);
        step(mk_lw(32'h000, 5'd2), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("wrap_data", wb_data, 32'h1234_5678);

        // misaligned store and load
        step(mk_sw(32'h42, 32'd1), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("mis_err_set", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 10; i++) step(nop(), 0, 0, 0);
        check("mis_err_sticky", 32'(misalign_err), 32'd1);
        step(mk_lw(32'h43, 5'd3), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("mis_load_zero", wb_data, 32'd0);
        step(mk_lw(32'h40, 5'd3), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("mis_store_blocked", wb_data, 32'hDEAD_BEEF);

        // reset with a store in MEM and an R-type in MEM/WB
        step(mk_alu(32'h99, 5'd9), 0, 0, 0);
        step(mk_sw(32'h80, 32'hAAAA_5555), 0, 0, 0);
        step(nop(), 0, 0, 1);
        check("rst_pc_src", 32'(pc_src), 32'd0);
        check("rst_branch_target", branch_target, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
        check("rst_wb_reg", 32'(wb_reg), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_misalign_err", 32'(misalign_err), 32'd0);
        step(mk_lw(32'h80, 5'd1), 0, 0, 0);
        step(nop(), 0, 0, 0);
        check("rst_store_suppressed", wb_data, dmem[32]);

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            step(rnd_instr(),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
